// File: rtl/parity_class_sched_pkg.sv
// rtl/parity_class_sched_pkg.sv - parity state encodings, class codes and update helpers
package parity_class_sched_pkg;

    // State bits are {odd1, odd0}: running parity of ones and zeros seen in the frame.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b10,
        S2 = 2'b01,
        S3 = 2'b11
    } pstate_t;

    localparam logic [3:0] CLS_A = 4'b1000;
    localparam logic [3:0] CLS_B = 4'b0100;
    localparam logic [3:0] CLS_C = 4'b0010;
    localparam logic [3:0] CLS_D = 4'b0001;

    function automatic pstate_t next_state(input pstate_t cur, input logic bit_in);
        logic [1:0] s;
        s = cur;
        if (bit_in) begin
            s[1] = ~s[1];
        end else begin
            s[0] = ~s[0];
        end
        return pstate_t'(s);
    endfunction

    function automatic logic [3:0] class_of(input pstate_t s);
        logic [3:0] c;
        case (s)
            S0:      c = CLS_A;
            S2:      c = CLS_B;
            S1:      c = CLS_C;
            default: c = CLS_D;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/parity_class_sched_rr_arbiter.sv
// rtl/parity_class_sched_rr_arbiter.sv - combinational round-robin grant from a start pointer
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] idx,
    output logic           any
);

    int j;

    // Scan NCH positions starting at ptr, wrapping; the first requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = CHW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_class_sched.sv
// rtl/parity_class_sched.sv - shared ones/zeros parity classifier time-shared across NCH serial channels
module parity_class_sched
    import parity_class_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] din,
    input  logic [NCH-1:0] last,
    output logic [NCH-1:0] gnt,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic [3:0]     out_cls,
    output logic           out_last
);

    logic [NCH-1:0] arb_gnt;
    logic [CHW-1:0] arb_idx;
    logic           arb_any;
    logic [CHW-1:0] ptr;
    logic [CHW-1:0] ptr_nxt;
    logic           take;
    pstate_t        st [NCH];
    pstate_t        cur_st;
    pstate_t        nxt_st;

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // clr wins over a same-cycle grant, so the offered bit is left with the requester.
    assign take = arb_any & ~clr;
    assign gnt  = (take && rst_n) ? arb_gnt : '0;

    always_comb begin
        cur_st  = st[arb_idx];
        nxt_st  = next_state(cur_st, din[arb_idx]);
        ptr_nxt = (arb_idx == CHW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st[i] <= S0;
            end
            ptr <= '0;
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                st[i] <= S0;
            end
            ptr <= '0;
        end else if (take) begin
            st[arb_idx] <= last[arb_idx] ? S0 : nxt_st;
            ptr         <= ptr_nxt;
        end
    end

    // Result fields hold between grants; out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_cls   <= 4'b0000;
            out_last  <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_ch    <= arb_idx;
            out_cls   <= class_of(nxt_st);
            out_last  <= last[arb_idx];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
